// File: rtl/sram_bist_engine.sv
`default_nettype none
// ============================================================================
// Module   : sram_bist_engine
// Purpose  : Built-in self-test requester for the SRAM controller's
//            processor-side port. On start it writes a pattern over an
//            address window, reads the window back and checks each word.
//            It reports pass/fail, a saturating error count and the first
//            failing address and data.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bist_engine #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int ERR_CNT_W      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [ERR_CNT_W-1:0]  err_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic [DATA_WIDTH-1:0] first_err_data_o,
  output logic                  req_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic                  ack_i,
  input  logic [DATA_WIDTH-1:0] rdata_i
);

  // Index runs one bit wider than the address so a full 2^ADDR_WIDTH window
  // can be counted.
  localparam int c_IDX_W = ADDR_WIDTH + 1;
  localparam logic [c_IDX_W-1:0] c_FULL_LEN = c_IDX_W'(1) << ADDR_WIDTH;

  // Watchdog counts cycles spent in the current wait state; it fires when
  // the state has been held for TIMEOUT_CYCLES cycles.
  localparam int c_WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LIMIT =
    c_WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_REQ    = 3'd1,
    S_WR_GAP    = 3'd2,
    S_RD_REQ    = 3'd3,
    S_RD_SAMPLE = 3'd4,
    S_RD_GAP    = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]            r_mode;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [c_IDX_W-1:0]    r_len;
  logic [c_IDX_W-1:0]    r_idx;
  logic [c_WD_W-1:0]     r_wd;
  logic                  r_timeout;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;
  logic [DATA_WIDTH-1:0] r_first_err_data;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_start;
  logic                  w_load;
  logic                  w_load_wdata;
  logic                  w_wr_en_nxt;
  logic                  w_fire;
  logic                  w_sample;
  logic [c_IDX_W-1:0]    w_idx_nxt;
  logic [c_IDX_W-1:0]    w_idx_inc;
  logic                  w_last;
  logic                  w_wd_expired;
  logic                  w_in_wait;
  logic [1:0]            w_mode_eff;
  logic [ADDR_WIDTH-1:0] w_base_eff;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic [DATA_WIDTH-1:0] w_expect;
  logic                  w_mismatch;

  // Test pattern for word idx under the given mode.
  function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [1:0]         mode,
                                                      input logic [c_IDX_W-1:0] idx);
    logic [DATA_WIDTH-1:0] p;
    int unsigned           sh;
    sh = 32'(idx) % 32'(DATA_WIDTH);
    p  = '0;
    case (mode)
      2'd0: p = DATA_WIDTH'(idx);
      2'd1: p = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << sh;
      2'd2: begin
        for (int b = 0; b < DATA_WIDTH; b++) begin
          p[b] = ((b % 2) == 0) ^ idx[0];
        end
      end
      default: p = ~DATA_WIDTH'(idx);
    endcase
    return p;
  endfunction

  // On the start edge the request outputs are built from the live inputs.
  assign w_mode_eff   = w_start ? mode_i : r_mode;
  assign w_base_eff   = w_start ? base_addr_i : r_base;
  assign w_idx_inc    = r_idx + 1'b1;
  assign w_last       = (w_idx_inc == r_len);
  assign w_wd_expired = (TIMEOUT_CYCLES != 0) && (r_wd == c_WD_LIMIT);
  assign w_in_wait    = (r_state == S_WR_REQ) || (r_state == S_WR_GAP) ||
                        (r_state == S_RD_REQ) || (r_state == S_RD_GAP);
  assign w_addr_nxt   = w_base_eff + w_idx_nxt[ADDR_WIDTH-1:0];
  assign w_wdata_nxt  = f_pattern(w_mode_eff, w_idx_nxt);
  assign w_expect     = f_pattern(r_mode, r_idx);
  assign w_mismatch   = w_sample && (rdata_i != w_expect);

  // Next-state, index advance and request-output load decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_start      = 1'b0;
    w_load       = 1'b0;
    w_load_wdata = 1'b0;
    w_wr_en_nxt  = r_wr_en;
    w_fire       = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_start      = 1'b1;
          w_state_nxt  = S_WR_REQ;
          w_idx_nxt    = '0;
          w_load       = 1'b1;
          w_load_wdata = 1'b1;
          w_wr_en_nxt  = 1'b1;
        end
      end
      S_WR_REQ: begin
        if (ack_i) begin
          w_state_nxt = S_WR_GAP;
        end else if (w_wd_expired) begin
          w_fire      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_WR_GAP: begin
        if (!ack_i) begin
          w_load = 1'b1;
          if (w_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_RD_REQ;
            w_wr_en_nxt = 1'b0;
          end else begin
            w_idx_nxt    = w_idx_inc;
            w_state_nxt  = S_WR_REQ;
            w_wr_en_nxt  = 1'b1;
            w_load_wdata = 1'b1;
          end
        end else if (w_wd_expired) begin
          w_fire      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_RD_REQ: begin
        if (ack_i) begin
          w_state_nxt = S_RD_SAMPLE;
        end else if (w_wd_expired) begin
          w_fire      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_RD_SAMPLE: begin
        w_sample    = 1'b1;
        w_state_nxt = S_RD_GAP;
      end
      S_RD_GAP: begin
        if (!ack_i) begin
          if (w_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_state_nxt = S_RD_REQ;
            w_load      = 1'b1;
            w_wr_en_nxt = 1'b0;
          end
        end else if (w_wd_expired) begin
          w_fire      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latched configuration and word index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= '0;
      r_base <= '0;
      r_len  <= '0;
      r_idx  <= '0;
    end else begin
      if (w_start) begin
        r_mode <= mode_i;
        r_base <= base_addr_i;
        r_len  <= (len_i == '0) ? c_FULL_LEN : {1'b0, len_i};
      end
      r_idx <= w_idx_nxt;
    end
  end

  // Watchdog: restarts on every state change, counts only while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else if (w_start || (w_state_nxt != r_state) || !w_in_wait) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end

  // Request outputs hold their last values outside the request states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_load) begin
      r_wr_en <= w_wr_en_nxt;
      r_addr  <= w_addr_nxt;
      if (w_load_wdata) begin
        r_wdata <= w_wdata_nxt;
      end
    end
  end

  // Result registers: cleared at start, updated on read compare and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout        <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_first_err_data <= '0;
    end else if (w_start) begin
      r_timeout        <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_first_err_data <= '0;
    end else begin
      if (w_fire) begin
        r_timeout <= 1'b1;
      end
      if (w_mismatch) begin
        // A saturating counter never returns to zero, so zero marks "no error yet".
        if (r_err_cnt == '0) begin
          r_first_err_addr <= r_addr;
          r_first_err_data <= rdata_i;
        end
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end
  end

  assign req_o            = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);
  assign busy_o           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o           = (r_state == S_DONE);
  assign pass_o           = done_o && (r_err_cnt == '0) && !r_timeout;
  assign timeout_o        = r_timeout;
  assign err_count_o      = r_err_cnt;
  assign first_err_addr_o = r_first_err_addr;
  assign first_err_data_o = r_first_err_data;
  assign wr_en_o          = r_wr_en;
  assign addr_o           = r_addr;
  assign wdata_o          = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_bist_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bist_engine
// Purpose  : Scoreboard bench for sram_bist_engine with a behavioural SRAM
//            (random ack delay/hold, stuck-at-1 faults) and a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bist_engine;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int EW = 8;
  localparam int TO = 16;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    mode_i = '0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW-1:0] len_i = '0;
  logic          ack_i = 1'b0;
  logic [DW-1:0] rdata_i = '0;
  logic          busy_o, done_o, pass_o, timeout_o, req_o, wr_en_o;
  logic [EW-1:0] err_count_o;
  logic [AW-1:0] first_err_addr_o, addr_o;
  logic [DW-1:0] first_err_data_o, wdata_o;

  always #5 clk = ~clk;

  sram_bist_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_CNT_W(EW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .timeout_o(timeout_o), .err_count_o(err_count_o),
    .first_err_addr_o(first_err_addr_o), .first_err_data_o(first_err_data_o),
    .req_o(req_o), .wr_en_o(wr_en_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .ack_i(ack_i), .rdata_i(rdata_i)
  );

  typedef struct { bit wr; int addr; int data; } txn_t;
  typedef struct { bit timeout; int err; int faddr; int fdata; } res_t;

  txn_t exp_q[$];
  res_t res_q[$];
  int   total = 0;
  int   bad = 0;

  // Behavioural SRAM state and knobs.
  int   mem[NW];
  int   stuck[NW];
  int   hold_cfg = 1;
  int   max_delay = 0;
  bit   dead = 1'b0;
  int   hold_left = 0;
  int   delay_left = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern rules written straight from the mode definitions (DW = 16).
  function automatic int ref_pat(int mode, int i);
    case (mode)
      0:       return i % 65536;
      1:       return 1 << (i % DW);
      2:       return (i % 2 == 0) ? 'h5555 : 'hAAAA;
      default: return (~i) & 'hFFFF;
    endcase
  endfunction

  // Expected write/read sequence and final result for one run.
  task automatic push_expect(int mode, int base, int len);
    int   n;
    int   cnt;
    int   fa;
    int   fd;
    int   rd;
    txn_t t;
    res_t r;
    n = (len == 0) ? NW : len;
    cnt = 0; fa = 0; fd = 0;
    for (int i = 0; i < n; i++) begin
      t.wr = 1'b1; t.addr = (base + i) % NW; t.data = ref_pat(mode, i);
      exp_q.push_back(t);
    end
    for (int i = 0; i < n; i++) begin
      t.wr = 1'b0; t.addr = (base + i) % NW; t.data = 0;
      exp_q.push_back(t);
      rd = ref_pat(mode, i) | stuck[t.addr];
      if (rd != ref_pat(mode, i)) begin
        if (cnt == 0) begin fa = t.addr; fd = rd; end
        cnt++;
      end
    end
    r.timeout = 1'b0;
    r.err = (cnt > 255) ? 255 : cnt;
    r.faddr = fa;
    r.fdata = fd;
    res_q.push_back(r);
  endtask

  task automatic pulse_start(int mode, int base, int len);
    mode_i      = mode[1:0];
    base_addr_i = base[AW-1:0];
    len_i       = len[AW-1:0];
    start_i     = 1'b1;
    @(negedge clk);
    start_i     = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n;
    n = 0;
    while (!done_o && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (!done_o) begin
      total++; bad++;
      $display("FAIL %s_done_wait: got done=0 expected done=1 within 10000 cycles", name);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run(string name, int mode, int base, int len);
    push_expect(mode, base, len);
    pulse_start(mode, base, len);
    wait_done(name);
  endtask

  // SRAM model: optional delay before ack, ack held hold_cfg cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack_i = 1'b0; hold_left = 0; delay_left = 0;
    end else if (ack_i) begin
      if (hold_left == 0) ack_i = 1'b0;
      else hold_left--;
    end else if (req_o && !dead) begin
      if (delay_left > 0) begin
        delay_left--;
      end else begin
        ack_i      = 1'b1;
        hold_left  = hold_cfg - 1;
        delay_left = $urandom_range(max_delay, 0);
        if (wr_en_o) mem[addr_o] = int'(wdata_o);
        else rdata_i = DW'(mem[addr_o] | stuck[addr_o]);
      end
    end
  end

  // Monitor: pops expectations on each accepted request and on done rising.
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    txn_t t;
    res_t r;
    #1;
    if (rst_n && req_o && ack_i) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_txn: got wr=%0d addr=0x%0h expected no request", wr_en_o, addr_o);
      end else begin
        t = exp_q.pop_front();
        check("txn_wr_en", 32'(wr_en_o), 32'(t.wr));
        check("txn_addr", 32'(addr_o), t.addr);
        if (t.wr) check("txn_wdata", 32'(wdata_o), t.data);
      end
    end
    if (rst_n && done_o && !prev_done) begin
      if (res_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        r = res_q.pop_front();
        check("res_timeout", 32'(timeout_o), 32'(r.timeout));
        check("res_err_count", 32'(err_count_o), r.err);
        check("res_first_err_addr", 32'(first_err_addr_o), r.faddr);
        check("res_first_err_data", 32'(first_err_data_o), r.fdata);
        check("res_pass", 32'(pass_o), 32'(r.err == 0 && !r.timeout));
        check("res_busy", 32'(busy_o), 0);
        check("res_missing_txns", exp_q.size(), 0);
      end
    end
    prev_done = done_o;
  end

  initial begin
    #900000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int   n;
    int   m;
    int   b;
    int   l;
    res_t r;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req", 32'(req_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_pass", 32'(pass_o), 0);
    check("rst_timeout", 32'(timeout_o), 0);
    check("rst_err_count", 32'(err_count_o), 0);
    check("rst_addr", 32'(addr_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic, stuck fault, wrap with walking one and checkerboard.
    run("basic", 0, 'h10, 2);
    stuck['hA5] = 1;
    run("fault", 3, 'hA4, 4);
    stuck['hA5] = 0;
    run("wrap_m1", 1, 'hFE, 4);
    run("wrap_m2", 2, 'hFE, 4);

    // Held ack plus a start pulse while busy.
    hold_cfg = 3; max_delay = 1;
    push_expect(0, 'h30, 5);
    pulse_start(0, 'h30, 5);
    repeat (6) @(negedge clk);
    check("busy_during_run", 32'(busy_o), 1);
    pulse_start(1, 'h00, 1);
    wait_done("handshake");
    hold_cfg = 1; max_delay = 0;

    // Watchdog with ack never asserted.
    dead = 1'b1;
    r.timeout = 1'b1; r.err = 0; r.faddr = 0; r.fdata = 0;
    res_q.push_back(r);
    pulse_start(0, 'h20, 3);
    n = 0;
    while (!req_o && n < 10) begin @(negedge clk); n++; end
    check("to_req_seen", 32'(req_o), 1);
    n = 0;
    while (!done_o && n < 40) begin @(negedge clk); n++; end
    check("to_latency_le17", 32'(n <= 17), 1);
    check("to_req_dropped", 32'(req_o), 0);
    check("to_done", 32'(done_o), 1);
    repeat (3) @(negedge clk);
    dead = 1'b0;

    // Asynchronous reset in the middle of the write phase.
    push_expect(2, 'h40, 8);
    pulse_start(2, 'h40, 8);
    n = 0;
    while (n < 60 && !(req_o && wr_en_o && addr_o == 8'h43)) begin @(negedge clk); n++; end
    check("mid_req_before_reset", 32'(req_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(req_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_done", 32'(done_o), 0);
    check("mid_rst_err", 32'(err_count_o), 0);
    exp_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("after_reset", 1, 'h80, 3);

    // Full 2^AW window (len 0) with random ack delays.
    max_delay = 2;
    run("full_window", $urandom_range(3, 0), $urandom_range(NW - 1, 0), 0);

    // Random runs with random faults and handshake timing.
    for (int k = 0; k < 8; k++) begin
      m = $urandom_range(3, 0);
      b = $urandom_range(NW - 1, 0);
      l = $urandom_range(24, 1);
      hold_cfg  = $urandom_range(3, 1);
      max_delay = $urandom_range(2, 0);
      for (int f = 0; f < $urandom_range(2, 0); f++) begin
        stuck[(b + $urandom_range(l - 1, 0)) % NW] |= 1 << $urandom_range(DW - 1, 0);
      end
      run("random", m, b, l);
      for (int a = 0; a < NW; a++) stuck[a] = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_bist_engine.md
Name: sram_bist_engine

Overview:
- Synthesizable built-in self-test master for the processor-side request port of the SRAM controller. It is the hardware successor of the directed write/read bench.
- On start it writes a parametrised data pattern over a configurable address window, reads the window back and compares every word.
- It reports pass/fail, an error count and the first failing address/data.
- It sits in the proc clock domain, in front of sram_controller, and replaces the CPU as requester during test.

Parameters:
- ADDR_WIDTH, 8, SRAM address width.
- DATA_WIDTH, 16, SRAM data width (>=2).
- ERR_CNT_W, 8, width of the saturating error counter.
- TIMEOUT_CYCLES, 256, maximum cycles waiting on any ack edge/level; 0 disables the watchdog.

Ports:
- clk  in  1  single clock (processor-side clock of the controller).
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle start strobe; ignored while busy_o=1.
- mode_i  in  2  pattern select, latched at start.
- base_addr_i  in  ADDR_WIDTH  first address, latched at start.
- len_i  in  ADDR_WIDTH  word count, latched at start; 0 means 2^ADDR_WIDTH words.
- busy_o  out  1  test in progress.
- done_o  out  1  level; test finished (normal or timeout).
- pass_o  out  1  valid when done_o=1.
- timeout_o  out  1  watchdog fired.
- err_count_o  out  ERR_CNT_W  number of mismatching words, saturating.
- first_err_addr_o  out  ADDR_WIDTH  address of first mismatch.
- first_err_data_o  out  DATA_WIDTH  data read at first mismatch.
- req_o  out  1  request to controller.
- wr_en_o  out  1  1=write, 0=read.
- addr_o  out  ADDR_WIDTH  request address.
- wdata_o  out  DATA_WIDTH  write data.
- ack_i  in  1  controller acknowledge.
- rdata_i  in  DATA_WIDTH  controller read data.

Behaviour:
- Reset (async, immediate):
  - All outputs are 0 and the FSM is in IDLE.
  - req_o drops at once, including mid-transaction.
  - Latched config and the index counter are cleared.
- FSM states: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_SAMPLE, RD_GAP, DONE.
- Start:
  - In IDLE or DONE, start_i=1 at an edge latches the config.
  - The same edge clears done_o, pass_o, timeout_o, err_count_o, first_err_* and sets index i=0.
  - The FSM moves to WR_REQ; busy_o=1 from the following cycle.
- Word i:
  - addr_o = base + i, modulo 2^ADDR_WIDTH (the window wraps).
  - pattern(i) by mode:
    - 0: i zero-extended/truncated to DATA_WIDTH.
    - 1: walking one, 1 << (i mod DATA_WIDTH).
    - 2: checkerboard, 0x5555... for even i and 0xAAAA... for odd i.
    - 3: inverted index, ~i truncated.
  - The index counter is ADDR_WIDTH+1 bits wide.
- WR_REQ:
  - Drives req_o=1, wr_en_o=1, addr_o and wdata_o; all are stable until ack.
  - At the first edge with ack_i=1, req_o=0 and the FSM moves to WR_GAP.
- WR_GAP:
  - req_o=0; waits until ack_i=0, minimum 1 cycle.
  - Then i++. If i==len, i=0 and the FSM moves to RD_REQ; otherwise back to WR_REQ.
  - A held ack is therefore counted once.
- RD_REQ: req_o=1, wr_en_o=0, addr_o stable. At the edge with ack_i=1, req_o=0 and the FSM moves to RD_SAMPLE.
- RD_SAMPLE: rdata_i is sampled at the next edge, i.e. one cycle after ack, and compared to pattern(i).
- On mismatch:
  - err_count increments, saturating at all-ones.
  - If this is the first error, first_err_addr/data capture the address and rdata_i.
  - The FSM then moves to RD_GAP.
- RD_GAP: like WR_GAP. After the last word the FSM moves to DONE.
- DONE:
  - busy_o=0, done_o=1.
  - pass_o=1 only if err_count==0 and timeout_o==0.
  - Held until the next start or reset.
- Watchdog:
  - A cycle counter runs in the *_REQ and *_GAP states and resets on every state change.
  - When it reaches TIMEOUT_CYCLES: timeout_o=1, req_o=0, FSM moves to DONE, pass_o=0.
- Outside WR_REQ and RD_REQ, req_o=0 and wr_en_o, addr_o, wdata_o hold their last values.
- start_i while busy has no effect.
- ack_i in IDLE or DONE is ignored.

Test Plan:
- Reset: assert rst_n=0 mid-write with req_o=1 -> req_o, busy_o, done_o and err_count_o are 0 immediately. After release, IDLE; the first start runs normally.
- Basic: ideal sram_model, mode 0, base 0x10, len 2 ->
  - writes 0x0000@0x10 and 0x0001@0x11, then reads both;
  - done_o=1, pass_o=1, err_count_o=0.
- Fault: model bit0 stuck-at-1 at 0xA5, mode 3, base 0xA4, len 4 ->
  - expected 0xFFFE@0xA5, read 0xFFFF;
  - err_count_o=1, first_err_addr_o=0xA5, first_err_data_o=0xFFFF, pass_o=0.
- Wrap and patterns: base 0xFE, len 4, modes 1 and 2 ->
  - addresses 0xFE, 0xFF, 0x00, 0x01;
  - mode 1 data 0x0001, 0x0002, 0x0004, 0x0008;
  - mode 2 data 0x5555, 0xAAAA, 0x5555, 0xAAAA;
  - pass_o=1.
- Timeout: ack_i tied 0, TIMEOUT_CYCLES=16 -> timeout_o=1, req_o=0, done_o=1 and pass_o=0 within 17 cycles of the first req_o.
- Handshake: ack held high 3 cycles per transaction, and start_i pulsed while busy -> each word is written/read exactly once and the second start is ignored.
